// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D): D has priority, with a starvation cap for I.
// Optional abort of stuck transactions is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int D_STREAK = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          stall_i,
  output logic          stall_d,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          bus_err
);
  localparam int SW = $clog2(D_STREAK + 1);

  if (D_STREAK < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("mem_port_arbiter: D_STREAK must be >= 1 and TIMEOUT must fit the 8-bit counter");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_flushed_q, i_flushed_d;
  logic          bus_err_q;
  logic          elig_i, elig_d, gnt_i, gnt_d, fin, abort;

  assign elig_d = d_req & ~d_done_q;
  assign elig_i = i_req & ~i_done_q & ~i_flush;
  assign gnt_d  = (state_q == IDLE) & elig_d & (~elig_i | (streak_q < SW'(D_STREAK)));
  assign gnt_i  = (state_q == IDLE) & elig_i & ~gnt_d;
  assign fin    = (state_q != IDLE) & (m_ack | abort);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign abort = (state_q != IDLE) & ~m_ack & (tmo_q == 8'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (gnt_d | gnt_i)        tmo_d = '0;
    else if (state_q != IDLE) tmo_d = tmo_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_flushed_d = i_flushed_q;

    // Streak only counts D wins that actually made a waiting fetch wait longer.
    if (!i_req || gnt_i)
      streak_d = '0;
    else if (gnt_d && elig_i && streak_q != SW'(D_STREAK))
      streak_d = streak_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (gnt_i) begin
          state_d     = BUSY_I;
          m_req_d     = 1'b1;
          m_we_d      = 1'b0;
          m_addr_d    = i_addr;
          m_wdata_d   = '0;
          i_flushed_d = 1'b0;
        end
      end
      BUSY_I: begin
        if (i_flush) i_flushed_d = 1'b1;
        if (fin) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          // A redirected fetch still drains the memory but must not reach the pipeline.
          if (!(i_flushed_q || i_flush)) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_ack ? m_rdata : '0;
          end
        end
      end
      BUSY_D: begin
        if (fin) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = m_ack ? m_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_flushed_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_flushed_q <= i_flushed_d;
      bus_err_q   <= abort;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;
  assign stall_i = i_req & ~i_done_q & ~i_flush;
  assign stall_d = d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; timeout checks are compiled in with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
  logic        clk, rst_n;
  logic        i_req, i_flush, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_done, d_done, stall_i, stall_d, m_req, m_we, bus_err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

  int   checks, errors;
  int   ack_dly;   // m_req cycles before ack; -1 means never ack
  int   rcnt;
  logic spur_ack;

  mem_port_arbiter #(.AW(32), .DW(32), .D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .stall_i(stall_i), .stall_d(stall_d),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word at 0x100 is 0xDEADBEEF, every other address reads addr ^ 0x5A5A0000.
  always begin
    @(posedge clk);
    #1;
    if (m_req && ack_dly >= 0 && rcnt >= ack_dly) begin
      m_ack   = 1'b1;
      m_rdata = (m_addr == 32'h100) ? 32'hDEADBEEF : (m_addr ^ 32'h5A5A0000);
      rcnt    = 0;
    end else begin
      m_ack   = spur_ack;
      m_rdata = 32'h0BAD0BAD;
      rcnt    = m_req ? rcnt + 1 : 0;
    end
  end

  // Inputs change at +2 after the edge, checks happen at +3.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    cyc(); #1;
    checks++;
    if ({m_req, m_we, i_done, d_done, bus_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {m_req, m_we, i_done, d_done, bus_err});
    end
    checks++;
    if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset_data got %h want 0", {m_addr, m_wdata, i_rdata, d_rdata});
    end
    cyc(); rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    cyc(); i_req = 1'b1; i_addr = 32'h100; #1;
    checks++;
    if ({stall_i, m_req} !== 2'b10) begin errors++; $display("FAIL fetch_c0 got %b want 10", {stall_i, m_req}); end
    cyc(); #1;
    checks++;
    if ({stall_i, m_req, m_we} !== 3'b110 || m_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_c1 got %b addr %h want 110 addr 100", {stall_i, m_req, m_we}, m_addr);
    end
    cyc(); #1;
    checks++;
    if ({i_done, stall_i, m_req} !== 3'b100 || i_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_c2 got %b rdata %h want 100 rdata deadbeef", {i_done, stall_i, m_req}, i_rdata);
    end
    cyc(); i_req = 1'b0; #1;
    checks++;
    if ({i_done, m_req} !== 2'b00) begin errors++; $display("FAIL fetch_c3 got %b want 00", {i_done, m_req}); end
  endtask

  task automatic test_d_priority();
    cyc(); i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; #1;
    checks++;
    if ({stall_i, stall_d} !== 2'b11) begin errors++; $display("FAIL prio_stall got %b want 11", {stall_i, stall_d}); end
    cyc(); #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h2000 || m_we !== 1'b0) begin
      errors++; $display("FAIL prio_dfirst got req %b addr %h want 1 2000", m_req, m_addr);
    end
    cyc(); #1;
    checks++;
    if ({d_done, stall_d, stall_i} !== 3'b101 || d_rdata !== 32'h5A5A2000) begin
      errors++; $display("FAIL prio_ddone got %b rdata %h want 101 5a5a2000", {d_done, stall_d, stall_i}, d_rdata);
    end
    cyc(); d_req = 1'b0; #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h100 || d_done !== 1'b0) begin
      errors++; $display("FAIL prio_igrant got req %b addr %h done %b want 1 100 0", m_req, m_addr, d_done);
    end
    cyc(); #1;
    checks++;
    if (i_done !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL prio_idone got %b %h want 1 deadbeef", i_done, i_rdata);
    end
    cyc(); i_req = 1'b0;
  endtask

  // D and I both held. i_flush follows d_done so I is not eligible in D's done cycle;
  // that leaves the streak cap as the only thing that lets I in. After the I grant the
  // D grant in the i_done cycle does not count (I not eligible), so round two has 5 D grants.
  task automatic test_streak();
    logic        prev;
    logic [10:0] exp_seq;
    bit          gseq[$];
    exp_seq = 11'b10000010000;
    prev = 1'b0;
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2010; i_req = 1'b1; i_addr = 32'h100; i_flush = 1'b0;
    for (int k = 0; k < 34; k++) begin
      if (k > 0) begin cyc(); i_flush = d_done; end
      #1;
      if (m_req && !prev) gseq.push_back(m_addr == 32'h100);
      prev = m_req;
    end
    cyc(); d_req = 1'b0; i_req = 1'b0; i_flush = 1'b0;
    repeat (4) cyc();
    checks++;
    if (gseq.size() < 11) begin
      errors++; $display("FAIL streak_count got %0d grants want >= 11", gseq.size());
    end else begin
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (gseq[k] !== exp_seq[k]) begin
          errors++; $display("FAIL streak_grant%0d got I=%0b want I=%0b", k, gseq[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    ack_dly = 3;
    cyc(); i_req = 1'b1; i_addr = 32'h300;
    cyc(); i_flush = 1'b1; #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h300 || stall_i !== 1'b0) begin
      errors++; $display("FAIL flush_busy got req %b addr %h stall %b want 1 300 0", m_req, m_addr, stall_i);
    end
    cyc(); i_flush = 1'b0; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
    cyc();
    cyc(); #1;
    checks++;
    if (m_req !== 1'b1 || m_ack !== 1'b1) begin
      errors++; $display("FAIL flush_drain got req %b ack %b want 1 1", m_req, m_ack);
    end
    cyc(); ack_dly = 0; #1;
    checks++;
    if ({i_done, m_req} !== 2'b00 || i_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL flush_nodone got %b rdata %h want 00 deadbeef", {i_done, m_req}, i_rdata);
    end
    cyc(); #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h2004) begin
      errors++; $display("FAIL flush_dgrant got %b %h want 1 2004", m_req, m_addr);
    end
    cyc(); #1;
    checks++;
    if ({d_done, i_done} !== 2'b10 || d_rdata !== 32'h5A5A2004) begin
      errors++; $display("FAIL flush_ddone got %b %h want 10 5a5a2004", {d_done, i_done}, d_rdata);
    end
    cyc(); d_req = 1'b0;
  endtask

  task automatic test_store_wait();
    int ndone;
    ndone = 0;
    ack_dly = 5;
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    for (int k = 1; k <= 6; k++) begin
      cyc(); #1;
      ndone += int'(d_done);
      checks++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'h12345678) begin
        errors++; $display("FAIL store_hold%0d got %b%b %h %h want 11 40 12345678", k, m_req, m_we, m_addr, m_wdata);
      end
    end
    cyc(); #1;
    ndone += int'(d_done);
    checks++;
    if ({d_done, m_req} !== 2'b10) begin errors++; $display("FAIL store_done got %b want 10", {d_done, m_req}); end
    cyc(); d_req = 1'b0; ack_dly = 0; #1;
    ndone += int'(d_done);
    repeat (3) begin cyc(); #1; ndone += int'(d_done); end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL store_once got %0d done pulses want 1", ndone); end
  endtask

  task automatic test_spurious_ack();
    cyc(); spur_ack = 1'b1;
    cyc(); spur_ack = 1'b0; #1;
    checks++;
    if (m_ack !== 1'b1) begin errors++; $display("FAIL spur_drive got %b want 1", m_ack); end
    cyc(); #1;
    checks++;
    if ({d_done, i_done, m_req} !== 3'b000 || d_rdata !== 32'h5A5A0040) begin
      errors++; $display("FAIL spur_ignored got %b %h want 000 5a5a0040", {d_done, i_done, m_req}, d_rdata);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    ack_dly = -1;
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
    for (int k = 1; k <= 8; k++) begin
      cyc(); #1;
      checks++;
      if ({m_req, bus_err, d_done} !== 3'b100) begin
        errors++; $display("FAIL tmo_busy%0d got %b want 100", k, {m_req, bus_err, d_done});
      end
    end
    cyc(); #1;
    checks++;
    if ({m_req, bus_err, d_done} !== 3'b011 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_abort got %b %h want 011 0", {m_req, bus_err, d_done}, d_rdata);
    end
    cyc(); d_req = 1'b0; ack_dly = 0; #1;
    checks++;
    if ({bus_err, d_done} !== 2'b00) begin errors++; $display("FAIL tmo_pulse got %b want 00", {bus_err, d_done}); end
  endtask
`else
  task automatic test_no_timeout();
    ack_dly = -1;
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
    repeat (20) cyc();
    #1;
    checks++;
    if ({m_req, bus_err, d_done} !== 3'b100) begin
      errors++; $display("FAIL notmo_wait got %b want 100", {m_req, bus_err, d_done});
    end
    ack_dly = 0;
    cyc(); cyc(); #1;
    checks++;
    if ({d_done, bus_err} !== 2'b10 || d_rdata !== 32'h5A5A2008) begin
      errors++; $display("FAIL notmo_done got %b %h want 10 5a5a2008", {d_done, bus_err}, d_rdata);
    end
    cyc(); d_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_busy();
    int bad;
    bad = 0;
    ack_dly = -1;
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hA5A5A5A5;
    cyc(); cyc(); #1;
    checks++;
    if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", m_req); end
    cyc(); rst_n = 1'b0; #1;
    checks++;
    if ({m_req, m_we, d_done, i_done, bus_err} !== 5'b0 || {m_addr, m_wdata, d_rdata, i_rdata} !== 128'b0) begin
      errors++; $display("FAIL rstmid_outs got %b %h want 0", {m_req, m_we, d_done, i_done, bus_err},
                         {m_addr, m_wdata, d_rdata, i_rdata});
    end
    d_req = 1'b0;
    cyc(); rst_n = 1'b1; ack_dly = 0;
    repeat (3) begin cyc(); #1; if (d_done !== 1'b0 || m_req !== 1'b0) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rstmid_after got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    checks = 0; errors = 0; ack_dly = 0; rcnt = 0; spur_ack = 1'b0;
    rst_n = 1'b0; i_req = 1'b0; i_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
    test_reset();
    test_single_fetch();
    test_d_priority();
    test_streak();
    test_flush();
    test_store_wait();
    test_spurious_ack();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
